// File: rtl/mcpu_prog_loader.sv
// -----------------------------------------------------------------------------
// mcpu_prog_loader
//
// Hardware program loader/dumper for the MCPU instruction RAM. A host stream
// (testbench or UART bridge) issues commands that zero-fill the RAM, stream
// instruction words into it, read it back out, or release the CPU from reset.
// The block owns the single RAM write/read port while it is busy.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready       command handshake; op 0=CLEAR 1=LOAD 2=DUMP 3=RUN
//   cmd_op/base/len       command fields, sampled in the accept cycle
//   in_valid/ready/data   load word stream (only consumed while loading)
//   out_valid/ready/data  dump word stream
//   mem_we/re/addr/wdata  RAM port; mem_rdata is valid one cycle after mem_re
//   mem_rdata
//   cpu_reset             active-high reset to the MCPU
//   busy                  high whenever the loader is not idle
//   done                  one-cycle pulse when a command completes
//   err                   one-cycle pulse when a command is rejected
// -----------------------------------------------------------------------------
module mcpu_prog_loader #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_SIZE-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_SIZE-1:0]  out_data,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LW = ADDR_WIDTH + 1;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_DUMP  = 2'd2;
  localparam logic [1:0] OP_RUN   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_FIN
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [LW-1:0]           r_len;
  logic [LW-1:0]           r_cnt;
  logic                    r_cpu_reset;
  logic                    r_err;
  logic                    r_hold;
  logic [WORD_SIZE-1:0]    r_out_data;

  logic                    w_accept;
  logic [LW:0]             w_end;
  logic                    w_range_bad;
  logic                    w_len_zero;
  logic                    w_last;
  logic                    w_clear_last;
  logic [ADDR_WIDTH-1:0]   w_idx_addr;
  logic                    w_cnt_inc;
  logic                    w_err_nxt;

  // cmd_ready is also forced low while reset is held so every handshake
  // output reads inactive during reset.
  assign cmd_ready    = (r_state == S_IDLE) & reset;
  assign w_accept     = cmd_valid & cmd_ready;

  // One extra bit on the sum so base+len can be compared against RAM_SIZE
  // without overflow; this is what guarantees addresses never wrap.
  assign w_end        = (LW+1)'(cmd_base) + (LW+1)'(cmd_len);
  assign w_range_bad  = (w_end > (LW+1)'(RAM_SIZE));
  assign w_len_zero   = (cmd_len == '0);

  assign w_last       = ((r_cnt + LW'(1)) == r_len);
  assign w_clear_last = (r_cnt == LW'(RAM_SIZE - 1));
  assign w_idx_addr   = r_base + r_cnt[ADDR_WIDTH-1:0];

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FIN);
  assign err          = r_err;

  // Non-RUN commands assert CPU reset combinationally in the accept cycle,
  // so the CPU never runs while its program is being rewritten.
  assign cpu_reset    = r_cpu_reset | (w_accept & (cmd_op != OP_RUN));

  // First DUMP_OUT cycle forwards the RAM read data directly (it is only
  // valid for that one cycle); afterwards the captured copy is shown.
  assign out_data     = ((r_state == S_DUMP_OUT) && !r_hold) ? mem_rdata : r_out_data;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and RAM/stream port decode
  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_RUN:   w_state_nxt = S_FIN;
            OP_CLEAR: w_state_nxt = S_CLEAR;
            default: begin
              if (w_range_bad) begin
                w_err_nxt = 1'b1;
              end else if (w_len_zero) begin
                w_state_nxt = S_FIN;
              end else if (cmd_op == OP_LOAD) begin
                w_state_nxt = S_LOAD;
              end else begin
                w_state_nxt = S_DUMP_RD;
              end
            end
          endcase
        end
      end

      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = r_cnt[ADDR_WIDTH-1:0];
        w_cnt_inc = 1'b1;
        if (w_clear_last) begin
          w_state_nxt = S_FIN;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_addr  = w_idx_addr;
          mem_wdata = in_data;
          w_cnt_inc = 1'b1;
          if (w_last) begin
            w_state_nxt = S_FIN;
          end
        end
      end

      S_DUMP_RD: begin
        mem_re      = 1'b1;
        mem_addr    = w_idx_addr;
        w_state_nxt = S_DUMP_OUT;
      end

      S_DUMP_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = w_last ? S_FIN : S_DUMP_RD;
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch, word counter, CPU reset and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_cpu_reset <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (w_accept) begin
        r_base      <= cmd_base;
        r_len       <= cmd_len;
        r_cnt       <= '0;
        r_cpu_reset <= (cmd_op != OP_RUN);
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + LW'(1);
      end
    end
  end

  // Dump output capture: r_hold marks that the forwarded word has been
  // stored and must be replayed from r_out_data until the consumer takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold     <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_hold <= (r_state == S_DUMP_OUT) && !out_ready;
      if ((r_state == S_DUMP_OUT) && !r_hold) begin
        r_out_data <= mem_rdata;
      end
    end
  end

endmodule
